// File: rtl/logic_unit_driver.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_driver
// Purpose  : Command-driven initiator for the combinational 8-bit logic unit.
//            Queues (x, y, op) commands in a small FIFO, issues each one to
//            the logic unit for a single cycle, captures the result and
//            returns it over a valid/ready response channel, in order.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            cmd_valid/cmd_ready  - command handshake (ready = FIFO not full)
//            cmd_x, cmd_y, cmd_op - operands and op (00 OR, 01 AND,
//                                   10 XOR, 11 NOT x)
//            lu_x, lu_y,
//            lu_sel1, lu_sel0     - registered drive to the logic unit
//            lu_f                 - combinational result from the logic unit
//            rsp_valid/rsp_ready  - response handshake
//            rsp_f, rsp_op        - captured result and the op that made it
//            busy                 - FIFO non-empty or FSM not idle
//            err                  - sticky golden-model mismatch flag
// Options  : define LU_DRIVER_CHECK_EN to enable the built-in result checker;
//            without it err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_driver #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_x,
   input  logic [WIDTH-1:0] cmd_y,
   input  logic [1:0]       cmd_op,
   output logic [WIDTH-1:0] lu_x,
   output logic [WIDTH-1:0] lu_y,
   output logic             lu_sel1,
   output logic             lu_sel0,
   input  logic [WIDTH-1:0] lu_f,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_f,
   output logic [1:0]       rsp_op,
   output logic             busy,
   output logic             err
);

   localparam int c_AW      = $clog2(DEPTH);
   localparam int c_ENTRY_W = 2 * WIDTH + 2;
   localparam logic [c_AW:0] c_PTR_ONE = (c_AW + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   // FIFO storage; entries are {x, y, op}
   logic [c_ENTRY_W-1:0] r_mem [DEPTH];
   logic [c_AW:0]        r_wr_ptr;
   logic [c_AW:0]        r_rd_ptr;
   state_t               r_state;

   logic [WIDTH-1:0]     r_lu_x;
   logic [WIDTH-1:0]     r_lu_y;
   logic                 r_lu_sel1;
   logic                 r_lu_sel0;
   logic                 r_rsp_valid;
   logic [WIDTH-1:0]     r_rsp_f;
   logic [1:0]           r_rsp_op;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic [c_ENTRY_W-1:0] w_head;
   logic [WIDTH-1:0]     w_head_x;
   logic [WIDTH-1:0]     w_head_y;
   logic [1:0]           w_head_op;

`ifdef LU_DRIVER_CHECK_EN
   logic                 r_err;
   logic [WIDTH-1:0]     w_expect_f;
`endif

   // Extra pointer MSB distinguishes full from empty when the index bits match
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

   // Full blocks a push even if a pop happens in the same cycle
   assign w_push  = cmd_valid && !w_full;

   // Pop from IDLE, or back-to-back when the pending response is consumed
   assign w_pop   = !w_empty &&
                    ((r_state == S_IDLE) ||
                     ((r_state == S_RESP) && r_rsp_valid && rsp_ready));

   assign w_head    = r_mem[r_rd_ptr[c_AW-1:0]];
   assign w_head_x  = w_head[c_ENTRY_W-1 -: WIDTH];
   assign w_head_y  = w_head[WIDTH+1 -: WIDTH];
   assign w_head_op = w_head[1:0];

   // Storage needs no reset: the pointers define which entries are valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_AW-1:0]] <= {cmd_x, cmd_y, cmd_op};
      end
   end

`ifdef LU_DRIVER_CHECK_EN
   always_comb begin
      w_expect_f = '0;
      case ({r_lu_sel1, r_lu_sel0})
         2'b00:   w_expect_f = r_lu_x | r_lu_y;
         2'b01:   w_expect_f = r_lu_x & r_lu_y;
         2'b10:   w_expect_f = r_lu_x ^ r_lu_y;
         default: w_expect_f = ~r_lu_x;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_state     <= S_IDLE;
         r_lu_x      <= '0;
         r_lu_y      <= '0;
         r_lu_sel1   <= 1'b0;
         r_lu_sel0   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_f     <= '0;
         r_rsp_op    <= 2'b00;
`ifdef LU_DRIVER_CHECK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end

         // Loading the unit's inputs happens on every pop; they then hold
         // their values until the next pop
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
            r_lu_x    <= w_head_x;
            r_lu_y    <= w_head_y;
            r_lu_sel1 <= w_head_op[1];
            r_lu_sel0 <= w_head_op[0];
         end

         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // lu_* were stable for the whole cycle, so lu_f has settled
               r_rsp_f     <= lu_f;
               r_rsp_op    <= {r_lu_sel1, r_lu_sel0};
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
`ifdef LU_DRIVER_CHECK_EN
               if (lu_f != w_expect_f) begin
                  r_err <= 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= w_empty ? S_IDLE : S_ISSUE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = !w_full;
   assign lu_x      = r_lu_x;
   assign lu_y      = r_lu_y;
   assign lu_sel1   = r_lu_sel1;
   assign lu_sel0   = r_lu_sel0;
   assign rsp_valid = r_rsp_valid;
   assign rsp_f     = r_rsp_f;
   assign rsp_op    = r_rsp_op;
   assign busy      = !w_empty || (r_state != S_IDLE);

`ifdef LU_DRIVER_CHECK_EN
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_driver
// Purpose  : Directed self-checking bench for logic_unit_driver. Provides a
//            behavioural logic unit (with an optional bit-0 corruption) and
//            checks latency, ordering, backpressure, reset and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_driver;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_x;
   logic [7:0] cmd_y;
   logic [1:0] cmd_op;
   logic [7:0] lu_x;
   logic [7:0] lu_y;
   logic       lu_sel1;
   logic       lu_sel0;
   logic [7:0] lu_f;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_f;
   logic [1:0] rsp_op;
   logic       busy;
   logic       err;
   logic       corrupt;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   logic exp_err;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [7:0] lu_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] op);
      case (op)
         2'b00:   return x | y;
         2'b01:   return x & y;
         2'b10:   return x ^ y;
         default: return ~x;
      endcase
   endfunction

   // Behavioural logic unit with a fault-injection hook on bit 0
   assign lu_f = lu_model(lu_x, lu_y, {lu_sel1, lu_sel0}) ^ {7'd0, corrupt};

   logic_unit_driver #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_op    (cmd_op),
      .lu_x      (lu_x),
      .lu_y      (lu_y),
      .lu_sel1   (lu_sel1),
      .lu_sel0   (lu_sel0),
      .lu_f      (lu_f),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_f     (rsp_f),
      .rsp_op    (rsp_op),
      .busy      (busy),
      .err       (err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and return one cycle after it is accepted; cmd_valid
   // is left high so consecutive calls form a back-to-back burst
   task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [1:0] op);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_x     = x;
      cmd_y     = y;
      cmd_op    = op;
      while (!cmd_ready && n < 100) begin
         step();
         n++;
      end
      if (!cmd_ready) check_val("push_timeout", cmd_ready, 1);
      step();
   endtask

   // Wait for a response (ready held high, or toggled randomly) and check it
   task automatic get_rsp(input string tag, input logic [7:0] ef, input logic [1:0] eop,
                          input bit rnd, output int at);
      int n = 0;
      at = -1;
      rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!(rsp_valid && rsp_ready) && n < 200) begin
         step();
         n++;
         rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
         check_val({tag, "_f"}, rsp_f, ef);
         check_val({tag, "_op"}, rsp_op, eop);
         check_val({tag, "_sel"}, {lu_sel1, lu_sel0}, eop);
         at = cyc;
         step();
      end else begin
         check_val({tag, "_timeout"}, rsp_valid, 1);
      end
   endtask

   logic [7:0] bx [6];
   logic [7:0] by [6];
   logic [1:0] bop[6];
   logic [7:0] rx [10];
   logic [7:0] ry [10];
   logic [1:0] rop[10];
   int         at4[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int n;
`ifdef LU_DRIVER_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_op = '0;
      rsp_ready = 1'b0; corrupt = 1'b0;
      repeat (3) step();

      // Reset state
      check_val("rst_cmd_ready", cmd_ready, 1);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_lu", {lu_x, lu_y, lu_sel1, lu_sel0}, 0);
      check_val("rst_rsp", {rsp_f, rsp_op}, 0);
      check_val("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      // Single OR with exact latency
      rsp_ready = 1'b1;
      push(8'h6C, 8'h17, 2'b00);
      cmd_valid = 1'b0;
      check_val("lat1_valid", rsp_valid, 0);
      check_val("lat1_busy", busy, 1);
      step();
      check_val("lat2_lu", {lu_x, lu_y, lu_sel1, lu_sel0}, {8'h6C, 8'h17, 2'b00});
      check_val("lat2_valid", rsp_valid, 0);
      step();
      check_val("lat3_valid", rsp_valid, 1);
      check_val("lat3_f", rsp_f, 8'h7F);
      check_val("lat3_op", rsp_op, 2'b00);
      step();
      check_val("lat4_valid", rsp_valid, 0);
      check_val("lat4_busy", busy, 0);
      check_val("err_clean", err, 0);

      // Four ops back-to-back, one response every two cycles
      fork
         begin
            push(8'h6C, 8'h17, 2'b00);
            push(8'h6C, 8'h17, 2'b01);
            push(8'h6C, 8'h17, 2'b10);
            push(8'h6C, 8'h17, 2'b11);
            cmd_valid = 1'b0;
         end
         begin
            get_rsp("b2b_or",  8'h7F, 2'b00, 0, at4[0]);
            get_rsp("b2b_and", 8'h04, 2'b01, 0, at4[1]);
            get_rsp("b2b_xor", 8'h7B, 2'b10, 0, at4[2]);
            get_rsp("b2b_not", 8'h93, 2'b11, 0, at4[3]);
         end
      join
      for (int i = 1; i < 4; i++) check_val("b2b_spacing", at4[i] - at4[i-1], 2);
      check_val("err_clean2", err, 0);

      // Backpressure: DEPTH+1 accepted, the sixth refused
      rsp_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         bx[i] = 8'hA0 + 8'(i * 17);
         by[i] = 8'h3C;
         bop[i] = 2'(i);
      end
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1; cmd_x = bx[i]; cmd_y = by[i]; cmd_op = bop[i];
         check_val("bp_ready", cmd_ready, (i < 5) ? 1 : 0);
         step();
      end
      cmd_valid = 1'b0;
      check_val("bp_full_hold", cmd_ready, 0);
      for (int i = 0; i < 5; i++) get_rsp("bp", lu_model(bx[i], by[i], bop[i]), bop[i], 0, at);
      check_val("bp_ready_back", cmd_ready, 1);
      check_val("bp_busy", busy, 0);

      // Random commands with random rsp_ready; pointers wrap repeatedly
      for (int i = 0; i < 10; i++) begin
         rx[i] = 8'($urandom); ry[i] = 8'($urandom); rop[i] = 2'($urandom);
      end
      fork
         begin
            for (int i = 0; i < 10; i++) push(rx[i], ry[i], rop[i]);
            cmd_valid = 1'b0;
         end
         begin
            for (int i = 0; i < 10; i++) get_rsp("rnd", lu_model(rx[i], ry[i], rop[i]), rop[i], 1, at);
         end
      join
      rsp_ready = 1'b0;
      step();
      check_val("rnd_busy", busy, 0);

      // Reset mid-operation: one response pending, two queued
      push(8'h11, 8'h22, 2'b00);
      push(8'h33, 8'h44, 2'b01);
      push(8'h55, 8'h66, 2'b10);
      cmd_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin
         step();
         n++;
      end
      check_val("mid_valid", rsp_valid, 1);
      check_val("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_val("arst_valid", rsp_valid, 0);
      check_val("arst_busy", busy, 0);
      check_val("arst_ready", cmd_ready, 1);
      check_val("arst_out", {lu_x, lu_y, lu_sel1, lu_sel0, rsp_f, rsp_op}, 0);
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check_val("post_rst_quiet", {rsp_valid, busy}, 0);
      end

      // Checker: corrupt bit 0 during one issue
      corrupt = 1'b1;
      push(8'h55, 8'h0F, 2'b01);
      cmd_valid = 1'b0;
      get_rsp("bad", 8'h04, 2'b01, 0, at);
      corrupt = 1'b0;
      check_val("err_set", err, exp_err);
      push(8'h55, 8'h0F, 2'b10);
      cmd_valid = 1'b0;
      get_rsp("good", 8'h5A, 2'b10, 0, at);
      check_val("err_sticky", err, exp_err);
      rst_n = 1'b0;
      step();
      check_val("err_rst", err, 0);
      rst_n = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_unit_driver.md
# logic_unit_driver

Command-driven initiator for the 8-bit logic unit: it accepts queued (x, y, op) commands over a valid/ready interface, drives the logic unit's operand and select inputs, captures the unit's combinational result, and returns it over a valid/ready response interface. It is the issuing end of the logic-unit interface and sits between a sequencer or CPU-style controller and the purely combinational logic unit. A small command FIFO decouples the issuer from response backpressure.

## Interface
- WIDTH, 8, operand/result width; matches the logic unit
- DEPTH, 4, command FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept (= not full)
- cmd_x  in  WIDTH  operand x
- cmd_y  in  WIDTH  operand y
- cmd_op  in  2  00 OR, 01 AND, 10 XOR, 11 NOT x
- lu_x  out  WIDTH  to logic unit x
- lu_y  out  WIDTH  to logic unit y
- lu_sel1  out  1  to logic unit sel1 (= op[1])
- lu_sel0  out  1  to logic unit sel0 (= op[0])
- lu_f  in  WIDTH  from logic unit f
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumer ready
- rsp_f  out  WIDTH  captured result
- rsp_op  out  2  op that produced rsp_f
- busy  out  1  FIFO non-empty or FSM not IDLE
- err  out  1  sticky golden-model mismatch (see Configuration)

## Operation
- Push: cmd_valid && cmd_ready writes {x,y,op} at the FIFO tail. No bypass; a pushed entry is visible to the FSM the next cycle. When full, cmd_ready=0 even if a pop happens that cycle.
- FSM states IDLE, ISSUE, RESP.
- IDLE: FIFO non-empty → pop head, register lu_x/lu_y/lu_sel1/lu_sel0 → ISSUE.
- ISSUE (one cycle): lu_* stable; at end of cycle capture lu_f into rsp_f, op into rsp_op, set rsp_valid → RESP.
- RESP: hold rsp_valid, rsp_f, rsp_op stable until rsp_valid && rsp_ready. On handshake: FIFO non-empty → pop head in the same cycle, load lu_* → ISSUE; else → IDLE, rsp_valid=0.
- NOT op: lu_y is still driven with cmd_y; the result depends on x only.
- lu_* hold their last issued values in IDLE/RESP. rsp_f holds until the next capture.
- Responses are returned strictly in command order; no command is dropped or duplicated.
- FIFO pointers are log2(DEPTH)+1 bits. Full/empty are decided by the MSB comparison and wrap naturally.

## Timing
- Reset (async assert, sync release): FIFO empty, state IDLE, lu_x=lu_y=0, lu_sel1=lu_sel0=0, rsp_valid=0, rsp_f=0, rsp_op=0, err=0, busy=0, cmd_ready=1.
- Latency: command accepted in cycle t → popped t+1 → lu_* driven t+2 (ISSUE) → rsp_valid=1 at t+3.
- Sustained throughput with rsp_ready=1: one response per 2 cycles.
- Capacity under backpressure: DEPTH in FIFO plus 1 in flight, i.e. DEPTH+1 accepted before cmd_ready falls.
- Reset mid-operation discards all queued and in-flight commands. No response for them appears after release.
- The logic unit path is combinational. lu_f must settle within one clock period of lu_* change.

## Configuration
- LU_DRIVER_CHECK_EN defined: in ISSUE the block computes the expected result internally (OR/AND/XOR/NOT of the registered operands) and compares it with lu_f. A mismatch sets err, which stays set until reset. The response is still delivered with lu_f's value.
- Not defined: no checker logic; err is tied to 0.

## Test plan
- Single OR: x=0x6C, y=0x17, op=00 accepted at t, rsp_ready=1 → rsp_valid at t+3, rsp_f=0x7F, rsp_op=00.
- Four ops back-to-back on x=0x6C, y=0x17, rsp_ready=1 → responses 0x7F, 0x04, 0x7B, 0x93 in order, 2 cycles apart; lu_sel1/lu_sel0 track op.
- Backpressure, DEPTH=4, rsp_ready=0: push 6 commands back-to-back → 5 accepted, cmd_ready=0 on the 6th. Then raise rsp_ready → all 5 responses in order, cmd_ready returns to 1.
- Wrap: 10 random commands with random rsp_ready toggling → all results match the model and order is preserved across pointer wrap.
- Reset mid-op: rsp_valid=1 with 2 queued, pulse rst_n low → all outputs at reset values immediately; after release with no new commands, rsp_valid stays 0 and busy=0.
- With LU_DRIVER_CHECK_EN, corrupt bit 0 of lu_f during ISSUE → err=1 and stays 1 through later good ops until reset. Without the macro, same stimulus → err=0.
